fpga_io_filt: RTL
=================

# fpga_io_filt

Parametrised successor to the board-level FPGA I/O register stage, sitting between the pads and the register file. It carries CH channels of W bits in each direction. Outputs are registered to the pads with a defined reset value. Inputs pass through a multi-stage synchroniser and a per-bit debounce filter, then feed sticky, edge-selectable event flags and a single registered interrupt line.

## Interface
Parameters:
- CH, 3: number of channels.
- W, 32: bits per channel; N = CH*W is the total bit count.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- FILT_LEN, 4: consecutive stable cycles needed to accept an input change, 1..255.
- OUT_RST, 1'b1: reset level of every output_pad bit.
- IN_RST, 1'b1: reset level of synchroniser, filter and fpga_i bits.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fpga_o  in  N  output data from regs; channel c is bits [c*W +: W].
- output_pad  out  N  registered pad outputs.
- input_pad  in  N  asynchronous pad inputs.
- fpga_i  out  N  synchronised, debounced inputs to regs.
- rise_en  in  N  per-bit enable for rising-edge events.
- fall_en  in  N  per-bit enable for falling-edge events.
- evt_clr  in  N  per-bit write-one-to-clear pulse for evt.
- evt  out  N  sticky event flags.
- irq  out  1  registered OR of all evt bits.

## Operation
- Output path: `output_pad <= fpga_o` every cycle. There is no mode logic.
- Synchroniser: SYNC_STAGES flops per bit. The last stage is s.
- Filter: each bit has a counter cnt of ceil(log2(FILT_LEN+1)) bits and a filtered value f, where fpga_i = f.
  - s == f: cnt <= 0.
  - s != f and cnt < FILT_LEN-1: cnt <= cnt+1.
  - s != f and cnt == FILT_LEN-1: f <= s and cnt <= 0.
  - Any glitch of s lasting fewer than FILT_LEN cycles is rejected and restarts the count.
  - With FILT_LEN = 1, f follows s one cycle later.
- Events: on the edge where f changes 0→1 with rise_en set, or 1→0 with fall_en set, evt[b] <= 1.
  - The flag stays set until an evt_clr[b] pulse.
  - If set and clear occur in the same cycle, set wins and evt stays 1.
  - Enables are sampled on the edge where f updates.
  - Changing an enable never sets or clears a flag by itself.
- irq <= |evt, one cycle behind evt.
- Per-bit logic is independent; bits and channels never interact except through the irq OR.

## Timing
- Reset values:
  - output_pad = {N{OUT_RST}}.
  - Sync flops, f and fpga_i = {N{IN_RST}}.
  - cnt = 0, evt = 0, irq = 0.
- Reset asserted mid-filter or mid-event discards all progress immediately. The first post-reset edge behaves as after power-up.
- fpga_o → output_pad: 1 cycle.
- input_pad → fpga_i: the pad change is captured at edge E0, s updates at E(SYNC_STAGES-1), and f updates at E(SYNC_STAGES-1+FILT_LEN). With defaults that is E5, i.e. 6 edges counting E0.
- evt updates on the same edge as f. irq follows one edge later.
- evt_clr takes effect on the next edge (1 cycle).
- A pad held at IN_RST through reset produces no event after release.

## Test plan
- Reset: assert rst asynchronously, mid-cycle → output_pad = 32'hFFFFFFFF ×3, fpga_i = all ones, evt = 0 and irq = 0 before the next clk edge.
- Output latency: fpga_o channel 1 = 32'h12345678 for 1 cycle → output_pad[63:32] = 32'h12345678 exactly 1 edge later; other channels unchanged.
- Glitch reject: defaults, input_pad bit 0 driven low for 3 cycles then high → fpga_i[0] stays 1 and evt[0] stays 0. A 4-cycle low → fpga_i[0] = 0 at E5 after capture.
- Falling event: fall_en[70] = 1, rise_en = 0, pad bit 70 goes low and stays → evt[70] = 1 on the fpga_i update edge and irq = 1 one edge later. The later rising edge does not re-set the flag. evt_clr[70] pulse → evt = 0, then irq = 0 next edge.
- Set/clear collision: evt_clr[5] pulsed on the same edge a rising event sets bit 5 → evt[5] remains 1.
- Reset mid-filter: pad bit 10 low for 2 filtered cycles, then rst pulse, then pad held low → fpga_i[10] = 0 only after the full SYNC_STAGES+FILT_LEN latency from reset release, and evt[10] = 0 if fall_en = 0.

Source files
------------

// File: rtl/fpga_io_filt_if.sv
// Bundle between the register file and the pad ring for fpga_io_filt.
// Every signal is a level sampled on the rising edge. There is no valid/ready handshake.
// evt_clr is the only pulse: it is a one-cycle write-one-to-clear request.
interface fpga_io_filt_if #(
    parameter int N = 96
);
    logic [N-1:0] fpga_o;
    logic [N-1:0] output_pad;
    logic [N-1:0] input_pad;
    logic [N-1:0] fpga_i;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] evt_clr;
    logic [N-1:0] evt;
    logic         irq;

    modport master (
        output fpga_o, input_pad, rise_en, fall_en, evt_clr,
        input  output_pad, fpga_i, evt, irq
    );

    modport slave (
        input  fpga_o, input_pad, rise_en, fall_en, evt_clr,
        output output_pad, fpga_i, evt, irq
    );
endinterface

// File: rtl/fpga_io_filt.sv
// Pad I/O stage: registered outputs, and inputs that are synchronised and debounced.
// The debounced inputs drive sticky per-bit edge events and one registered interrupt.
module fpga_io_filt #(
    parameter int   CH          = 3,
    parameter int   W           = 32,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic OUT_RST     = 1'b1,
    parameter logic IN_RST      = 1'b1
) (
    input logic          clk,
    input logic          rst,
    fpga_io_filt_if.slave bus
);
    localparam int N  = CH * W;
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [N-1:0]                  out_q;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0]                  s;
    logic [N-1:0]                  f_q, f_d;
    logic [CW-1:0]                 cnt_q [N];
    logic [CW-1:0]                 cnt_d [N];
    logic [N-1:0]                  evt_q, evt_d;
    logic [N-1:0]                  rise_set, fall_set;
    logic                          irq_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.input_pad};
    assign s      = sync_q[SYNC_STAGES-1];

    // The count restarts whenever s agrees with f, so only an unbroken run of FILT_LEN disagreeing cycles flips f.
    always_comb begin
        f_d = f_q;
        for (int b = 0; b < N; b++) begin
            cnt_d[b] = '0;
            if (s[b] != f_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    f_d[b] = s[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Setting the flag takes priority over a clear in the same cycle, so no edge is lost.
    assign rise_set = f_d & ~f_q & bus.rise_en;
    assign fall_set = ~f_d & f_q & bus.fall_en;
    assign evt_d    = (evt_q & ~bus.evt_clr) | rise_set | fall_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= {N{OUT_RST}};
            sync_q <= {(SYNC_STAGES * N){IN_RST}};
            f_q    <= {N{IN_RST}};
            evt_q  <= '0;
            irq_q  <= 1'b0;
            for (int b = 0; b < N; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            out_q  <= bus.fpga_o;
            sync_q <= sync_d;
            f_q    <= f_d;
            evt_q  <= evt_d;
            irq_q  <= |evt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.output_pad = out_q;
    assign bus.fpga_i     = f_q;
    assign bus.evt        = evt_q;
    assign bus.irq        = irq_q;
endmodule
